// File: rtl/cdc_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer width and Gray-code conversion.
// Conversions work on 32-bit values; callers size-cast to their pointer width.
`timescale 1ns/10ps
package cdc_fifo_pkg;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < 32; i++) b = b ^ (g >> i);
      return b;
   endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
// Also serves as a reset synchronizer when d is tied high.
`timescale 1ns/10ps
module cdc_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // NOTE: non-blocking assignments make q take meta's pre-edge value, giving two real stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cdc_fifo.sv
// Asynchronous dual-clock FIFO: Gray pointers cross through 2-flop synchronizers,
// full/empty and fill levels are registered from next-state pointers in each domain.
`timescale 1ns/10ps
module cdc_fifo
   import cdc_fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                   clk_wr,
   input  logic                   clk_rd,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   output logic                   full,
   output logic                   almost_full,
   output logic [$clog2(DEPTH):0] wr_count,
   output logic                   overflow,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_valid,
   output logic                   empty,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] rd_count,
   output logic                   underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

   logic wr_rst_n, rd_rst_n;

   logic [DATA_W-1:0] mem [DEPTH];

   logic          wr_ok;
   logic [PW-1:0] wr_bin, wr_gray, wr_bin_nxt, wr_gray_nxt, wr_count_nxt;
   logic [PW-1:0] rd_gray_s, rd_bin_s;

   logic          rd_ok;
   logic [PW-1:0] rd_bin, rd_gray, rd_bin_nxt, rd_gray_nxt, rd_count_nxt;
   logic [PW-1:0] wr_gray_s, wr_bin_s;

   // Assertion is immediate in both domains; release is synchronised per domain.
   cdc_sync2 #(.WIDTH(1)) u_wr_rst_sync (
      .clk   (clk_wr),
      .rst_n (rst_n),
      .d     (1'b1),
      .q     (wr_rst_n)
   );

   cdc_sync2 #(.WIDTH(1)) u_rd_rst_sync (
      .clk   (clk_rd),
      .rst_n (rst_n),
      .d     (1'b1),
      .q     (rd_rst_n)
   );

   cdc_sync2 #(.WIDTH(PW)) u_rd2wr_sync (
      .clk   (clk_wr),
      .rst_n (wr_rst_n),
      .d     (rd_gray),
      .q     (rd_gray_s)
   );

   cdc_sync2 #(.WIDTH(PW)) u_wr2rd_sync (
      .clk   (clk_rd),
      .rst_n (rd_rst_n),
      .d     (wr_gray),
      .q     (wr_gray_s)
   );

   // ---------------- write domain ----------------
   assign wr_ok        = wr_en & ~full;
   assign wr_bin_nxt   = wr_bin + PW'(wr_ok);
   assign wr_gray_nxt  = PW'(bin2gray(32'(wr_bin_nxt)));
   assign rd_bin_s     = PW'(gray2bin(32'(rd_gray_s)));
   assign wr_count_nxt = wr_bin_nxt - rd_bin_s;

   // Flags use next-state pointers so a write that fills the FIFO blocks the very next one.
   always_ff @(posedge clk_wr or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         wr_bin      <= '0;
         wr_gray     <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_count    <= '0;
         overflow    <= 1'b0;
      end else begin
         wr_bin      <= wr_bin_nxt;
         wr_gray     <= wr_gray_nxt;
         full        <= (wr_gray_nxt == {~rd_gray_s[PW-1:PW-2], rd_gray_s[PW-3:0]});
         wr_count    <= wr_count_nxt;
         almost_full <= (wr_count_nxt >= AF_L);
         if (wr_en && full) overflow <= 1'b1;
      end
   end

   // NOTE: storage has no reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk_wr) begin
      if (wr_ok) mem[wr_bin[AW-1:0]] <= wr_data;
   end

   // ---------------- read domain ----------------
   assign rd_ok        = rd_en & ~empty;
   assign rd_bin_nxt   = rd_bin + PW'(rd_ok);
   assign rd_gray_nxt  = PW'(bin2gray(32'(rd_bin_nxt)));
   assign wr_bin_s     = PW'(gray2bin(32'(wr_gray_s)));
   assign rd_count_nxt = wr_bin_s - rd_bin_nxt;

   always_ff @(posedge clk_rd or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         rd_bin       <= '0;
         rd_gray      <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_count     <= '0;
         rd_valid     <= 1'b0;
         rd_data      <= '0;
         underflow    <= 1'b0;
      end else begin
         rd_bin       <= rd_bin_nxt;
         rd_gray      <= rd_gray_nxt;
         empty        <= (rd_gray_nxt == wr_gray_s);
         rd_count     <= rd_count_nxt;
         almost_empty <= (rd_count_nxt <= AE_L);
         rd_valid     <= rd_ok;
         if (rd_ok) rd_data <= mem[rd_bin[AW-1:0]];
         if (rd_en && empty) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cdc_fifo.sv
// Directed bench for cdc_fifo: reset state, fill/drain, overflow/underflow,
// interleaved traffic across pointer wraps, mid-operation reset, empty latency.
`timescale 1ns/10ps
module tb_cdc_fifo;

   logic       clk_wr = 1'b0;
   logic       clk_rd = 1'b0;
   logic       rst_n  = 1'b0;
   logic       wr_en  = 1'b0;
   logic       rd_en  = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, almost_full, overflow, rd_valid, empty, almost_empty, underflow;
   logic [7:0] rd_data;
   logic [4:0] wr_count, rd_count;

   // Write edges stay on integer times, read rising edges on half-integer times.
   realtime wr_half = 5.0;
   realtime rd_half = 13.5;

   int vectors     = 0;
   int miscompares = 0;

   int         sent, got, wmax, rmax;
   logic [7:0] d;
   logic       v;

   cdc_fifo #(
      .DATA_W   (8),
      .DEPTH    (16),
      .AF_LEVEL (14),
      .AE_LEVEL (2)
   ) dut (
      .clk_wr       (clk_wr),
      .clk_rd       (clk_rd),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .almost_full  (almost_full),
      .wr_count     (wr_count),
      .overflow     (overflow),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .empty        (empty),
      .almost_empty (almost_empty),
      .rd_count     (rd_count),
      .underflow    (underflow)
   );

   initial forever #(wr_half) clk_wr = ~clk_wr;
   initial forever #(rd_half) clk_rd = ~clk_rd;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
         $error("check %s did not hold", tag);
      end
   endtask

   function automatic logic [7:0] pat(input int n);
      return 8'(n * 37 + 11);
   endfunction

   task automatic write_word(input logic [7:0] wd);
      @(negedge clk_wr);
      wr_en   = 1'b1;
      wr_data = wd;
      @(negedge clk_wr);
      wr_en   = 1'b0;
   endtask

   task automatic read_word(output logic [7:0] rdat, output logic rval);
      @(negedge clk_rd);
      rd_en = 1'b1;
      @(negedge clk_rd);
      rd_en = 1'b0;
      rdat  = rd_data;
      rval  = rd_valid;
   endtask

   // One write into an empty FIFO; count read edges until empty drops (limit 3).
   task automatic empty_latency(input string tag);
      int         n;
      logic [7:0] ld;
      logic       lv;
      n = 0;
      @(negedge clk_wr);
      wr_en   = 1'b1;
      wr_data = 8'hC3;
      @(posedge clk_wr);
      fork
         begin
            @(negedge clk_wr);
            wr_en = 1'b0;
         end
      join_none
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk_rd);
         @(negedge clk_rd);
         if (!empty) begin
            n = k;
            break;
         end
      end
      check({tag, "_empty_within_3"}, 32'(n >= 1 && n <= 3), 1);
      read_word(ld, lv);
      check({tag, "_valid"}, 32'(lv), 1);
      check({tag, "_data"}, 32'(ld), 32'hC3);
      repeat (2) @(negedge clk_wr);
   endtask

   initial begin
      // ---- reset state ----
      #50;
      check("rst_empty",        32'(empty), 1);
      check("rst_almost_empty", 32'(almost_empty), 1);
      check("rst_full",         32'(full), 0);
      check("rst_almost_full",  32'(almost_full), 0);
      check("rst_wr_count",     32'(wr_count), 0);
      check("rst_rd_count",     32'(rd_count), 0);
      check("rst_rd_valid",     32'(rd_valid), 0);
      check("rst_rd_data",      32'(rd_data), 0);
      check("rst_overflow",     32'(overflow), 0);
      check("rst_underflow",    32'(underflow), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_rd);

      // ---- read while empty ----
      read_word(d, v);
      check("uf_rd_valid", 32'(v), 0);
      check("uf_rd_data",  32'(d), 0);
      check("uf_flag",     32'(underflow), 1);
      @(negedge clk_rd);
      check("uf_sticky",   32'(underflow), 1);

      // ---- fill 0x00..0x0F ----
      for (int i = 0; i < 16; i++) begin
         write_word(8'(i));
         check($sformatf("fill_af_%0d", i),   32'(almost_full), 32'(i >= 13));
         check($sformatf("fill_full_%0d", i), 32'(full),        32'(i == 15));
      end
      check("fill_wr_count", 32'(wr_count), 16);

      // ---- write while full ----
      write_word(8'hAA);
      check("of_flag",     32'(overflow), 1);
      check("of_full",     32'(full), 1);
      check("of_wr_count", 32'(wr_count), 16);

      repeat (4) @(negedge clk_rd);
      check("pre_drain_rd_count", 32'(rd_count), 16);
      check("pre_drain_empty",    32'(empty), 0);
      check("pre_drain_ae",       32'(almost_empty), 0);

      // ---- drain ----
      for (int i = 0; i < 16; i++) begin
         read_word(d, v);
         check($sformatf("drain_valid_%0d", i), 32'(v), 1);
         check($sformatf("drain_data_%0d", i),  32'(d), 32'(i));
         check($sformatf("drain_ae_%0d", i),    32'(almost_empty), 32'((15 - i) <= 2));
      end
      check("drain_empty",        32'(empty), 1);
      check("drain_rd_count",     32'(rd_count), 0);
      check("drain_uf_sticky",    32'(underflow), 1);
      repeat (4) @(negedge clk_wr);
      check("drain_full",         32'(full), 0);
      check("drain_wr_count",     32'(wr_count), 0);
      check("drain_of_sticky",    32'(overflow), 1);

      // ---- interleaved traffic with random gaps ----
      sent = 0; got = 0; wmax = 0; rmax = 0;
      fork
         begin
            for (int c = 0; c < 2000 && sent < 40; c++) begin
               @(negedge clk_wr);
               if (int'(wr_count) > wmax) wmax = int'(wr_count);
               if (!full && $urandom_range(0, 2) != 0) begin
                  wr_en   = 1'b1;
                  wr_data = pat(sent);
                  sent++;
               end else begin
                  wr_en = 1'b0;
               end
            end
            @(negedge clk_wr);
            wr_en = 1'b0;
         end
         begin
            for (int c = 0; c < 3000 && got < 40; c++) begin
               @(negedge clk_rd);
               if (int'(rd_count) > rmax) rmax = int'(rd_count);
               if (rd_valid) begin
                  check($sformatf("il_data_%0d", got), 32'(rd_data), 32'(pat(got)));
                  got++;
               end
               rd_en = (got < 40) && !empty && ($urandom_range(0, 3) != 0);
            end
            rd_en = 1'b0;
         end
      join
      check("il_received",      32'(got), 40);
      check("il_wr_count_max",  32'(wmax <= 16), 1);
      check("il_rd_count_max",  32'(rmax <= 16), 1);
      repeat (4) @(negedge clk_rd);
      check("il_empty",         32'(empty), 1);

      // ---- reset with 5 entries held ----
      for (int i = 0; i < 5; i++) write_word(8'(8'h10 + i));
      repeat (4) @(negedge clk_rd);
      check("hold5_rd_count", 32'(rd_count), 5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_empty",     32'(empty), 1);
      check("mid_rst_full",      32'(full), 0);
      check("mid_rst_wr_count",  32'(wr_count), 0);
      check("mid_rst_rd_count",  32'(rd_count), 0);
      check("mid_rst_overflow",  32'(overflow), 0);
      check("mid_rst_underflow", 32'(underflow), 0);
      #20;
      rst_n = 1'b1;
      repeat (4) @(negedge clk_rd);
      write_word(8'h5A);
      repeat (4) @(negedge clk_rd);
      read_word(d, v);
      check("post_rst_valid", 32'(v), 1);
      check("post_rst_data",  32'(d), 32'h5A);
      @(negedge clk_rd);
      check("post_rst_empty", 32'(empty), 1);
      check("post_rst_valid_drop", 32'(rd_valid), 0);

      // ---- empty deassert latency at two clock ratios ----
      wr_half = 5.0;
      rd_half = 15.5;
      repeat (3) @(negedge clk_rd);
      empty_latency("ratio_1to3");
      wr_half = 16.0;
      rd_half = 5.5;
      repeat (3) @(negedge clk_wr);
      empty_latency("ratio_3to1");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cdc_fifo.md
CDC_FIFO -- requirements
Module: cdc_fifo

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, data word width in bits.
REQ-002 The block SHALL provide parameter DEPTH, default 16, entry count; power of two, >= 4.
REQ-003 The block SHALL provide parameter AF_LEVEL, default DEPTH-2, write-side fill level at or above which almost_full asserts.
REQ-004 The block SHALL provide parameter AE_LEVEL, default 2, read-side fill level at or below which almost_empty asserts.
REQ-005 The block SHALL have port clk_wr, input, 1 bit, write-domain clock.
REQ-006 The block SHALL have port clk_rd, input, 1 bit, read-domain clock, asynchronous to clk_wr.
REQ-007 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-008 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-009 The block SHALL have port wr_data, input, DATA_W bits, write data.
REQ-010 The block SHALL have ports full and almost_full, outputs, 1 bit each, clk_wr-domain status.
REQ-011 The block SHALL have port wr_count, output, log2(DEPTH)+1 bits, write-side fill level.
REQ-012 The block SHALL have port overflow, output, 1 bit, sticky write-to-full error.
REQ-013 The block SHALL have port rd_en, input, 1 bit, read request.
REQ-014 The block SHALL have ports rd_data (DATA_W) and rd_valid (1), outputs, registered read data and its qualifier.
REQ-015 The block SHALL have ports empty and almost_empty, outputs, 1 bit each, clk_rd-domain status.
REQ-016 The block SHALL have ports rd_count (log2(DEPTH)+1 bits) and underflow (1 bit), outputs, read-side fill level and sticky read-from-empty error.

Function
REQ-017 A write SHALL be accepted on a clk_wr rising edge when wr_en=1 and full=0; it stores wr_data and increments the write pointer.
REQ-018 A read SHALL be accepted on a clk_rd rising edge when rd_en=1 and empty=0; rd_data takes the oldest entry and rd_valid=1 on the following cycle, with 1-cycle latency.
REQ-019 rd_valid SHALL be 0 in any cycle not following an accepted read; rd_data SHALL hold its last value otherwise.
REQ-020 Pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; the MSB distinguishes full from empty.
REQ-021 Pointers SHALL cross domains only in Gray code, through a 2-flop synchronizer per crossing.
REQ-022 full SHALL equal (wr_gray == synced rd_gray with its two MSBs inverted), registered in clk_wr; empty SHALL equal (rd_gray == synced wr_gray), registered in clk_rd.
REQ-023 Flags SHALL be pessimistic only: full/empty may lag a freeing event but SHALL never indicate space or data that does not exist.
REQ-024 A write into an empty FIFO SHALL deassert empty no later than the 3rd clk_rd rising edge after the write edge; a read from a full FIFO SHALL deassert full within 3 clk_wr edges.
REQ-025 wr_count SHALL be wr_bin minus synced rd_bin, mod 2*DEPTH; rd_count SHALL be the mirror image; both SHALL stay within 0..DEPTH.
REQ-026 almost_full SHALL be (wr_count >= AF_LEVEL); almost_empty SHALL be (rd_count <= AE_LEVEL).
REQ-027 wr_en with full=1 SHALL discard data, leave pointers unchanged, and set overflow until reset; rd_en with empty=1 SHALL leave rd_data unchanged and set underflow until reset.
REQ-028 Simultaneous reads and writes in their respective domains SHALL both be accepted whenever their own flag permits.

Reset
REQ-029 rst_n low SHALL asynchronously clear all pointers, synchronizers, counts, rd_valid, overflow and underflow, forcing empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0.
REQ-030 Reset deassertion SHALL be synchronised inside the block, separately per domain, through a 2-flop reset synchronizer.
REQ-031 Storage memory SHALL NOT be reset; reset mid-operation SHALL discard all contents.

Structure
REQ-032 Package cdc_fifo_pkg SHALL hold the bin2gray/gray2bin functions and the pointer-width constant function.
REQ-033 Sub-module cdc_sync2 (parametrised width, 2-flop, async reset) SHALL be used for both pointer crossings and both reset synchronizers.

Verification
REQ-034 With clk_wr=100 MHz, clk_rd=37 MHz, write 0x00..0x0F: almost_full asserts after the 14th write and full after the 16th; 16 reads return 0x00..0x0F in order, then empty=1.
REQ-035 Write 0xAA while full: data is not stored, overflow=1 and holds until rst_n; subsequent reads return no 0xAA.
REQ-036 rd_en while empty: rd_valid stays 0, underflow=1 and is sticky.
REQ-037 Drive 40 interleaved writes/reads with random gaps: order is preserved across pointer wraps at 16 and 32, and wr_count/rd_count never exceed 16.
REQ-038 Reset with 5 entries held: empty=1, full=0, counts=0; after release, write 0x5A then read returns 0x5A with rd_valid=1.
REQ-039 A single write into an empty FIFO deasserts empty within 3 clk_rd edges; this SHALL be checked at clock ratios 1:3 and 3:1.
